disp_scan_ctrl: RTL and testbench
=================================

// Module: disp_scan_ctrl
// PURPOSE
//   Upstream scan controller for the 4-digit time-multiplexed display path.
//   It generates the 2-bit select that drives the downstream 4:1 N-bit digit mux.
//   It also generates the matching active-low digit anodes, with a blanking gap and brightness PWM.
//   It sits between the system clock domain and the mux/segment-decoder pair.
// PARAMETERS
//   TICK_DIV   100_000  clk cycles per digit slot; legal range TICK_DIV > BLANK_CYC
//   BLANK_CYC  1_000    cycles at the start of each slot with all anodes off (anti-ghosting); legal range >= 1
//   Elaboration-time assertion enforces: TICK_DIV > BLANK_CYC >= 1.
// PORTS
//   clk         in   1    system clock, rising edge
//   reset_n     in   1    asynchronous, active-low reset
//   en          in   1    scan enable; 0 freezes counters and blanks anodes
//   digit_mask  in   4    bit k=1 allows digit k to light
//   bright      in   4    duty code; 0=off, 15=full on-window
//   sel         out  2    digit select to the 4:1 mux (s input)
//   an_n        out  4    active-low anodes; at most one bit low
//   slot_start  out  1    one-cycle pulse when a new slot begins
// BEHAVIOUR
//   - Reset (async, reset_n=0): cnt=0, sel=0, an_n=4'hF, slot_start=0.
//     All outputs take these values immediately, without waiting for a clock edge.
//   - State: cnt [$clog2(TICK_DIV)-1:0] counts 0..TICK_DIV-1; sel is a mod-4 counter.
//   - en=1, each edge:
//     cnt <= (cnt==TICK_DIV-1) ? 0 : cnt+1.
//     sel increments on the cnt wrap (3 wraps to 0).
//   - en=0: cnt and sel hold; an_n <= 4'hF; slot_start <= 0. Scan resumes from the held state when en returns to 1.
//   - lit(k) = en && k==sel' && digit_mask[k] && cnt' >= BLANK_CYC && (bright==4'hF || cnt'[3:0] < bright).
//     Primes (cnt', sel') denote next-state values.
//   - an_n is registered from next-state values, so an_n, sel and cnt change on the same edge (zero lag).
//     There is no cycle where the new sel shows with the old anode.
//   - slot_start <= en && (cnt==TICK_DIV-1). It is high during the cycle in which cnt==0 after a wrap.
//     It stays low after reset until the first wrap.
//   - Digit masking keeps the slot and refresh rate constant: a masked digit's slot is dark.
//   - digit_mask and bright are sampled every cycle. Changes take effect on the next edge with no glitch,
//     because an_n is registered.
//   - Refresh rate per digit = f_clk / (4*TICK_DIV).
// STRUCTURE
//   - disp_pkg holds NUM_DIG=4, SEL_W=2, BRIGHT_W=4, BRIGHT_FULL=4'hF,
//     and function dig_onehot(sel) returning a 4-bit one-hot.
//   - Sub-module mod_counter #(M):
//     - ports: clk, reset_n, en, cnt, wrap, where wrap = en && cnt==M-1.
//     - instantiated twice: slot counter (M=TICK_DIV) and digit counter (M=4, en = slot wrap).
//   - Top-level logic covers the lit() compare, the an_n register and the slot_start register.
// TESTING (bench params TICK_DIV=8, BLANK_CYC=2)
//   1 Reset:
//     - reset_n=0 for 3 cycles -> an_n=4'hF, sel=0, slot_start=0 throughout.
//     - After release with en=1, first slot_start occurs at cycle 8.
//   2 Full scan (mask=4'hF, bright=15):
//     - sel steps 0,1,2,3,0 every 8 cycles.
//     - In the sel=0 slot, an_n=4'b1110 for cnt=2..7 and 4'hF for cnt=0..1.
//     - Pattern repeats for 4'b1101, 4'b1011, 4'b0111.
//   3 Mask 4'b0101:
//     - an_n bits 1 and 3 never go low.
//     - sel still cycles 0..3 with 8-cycle slots, so slot_start period stays 8.
//   4 Brightness:
//     - bright=4 -> exactly 2 lit cycles per slot (cnt=2,3).
//     - bright=0 -> an_n=4'hF always.
//     - bright=15 -> 6 lit cycles per slot.
//   5 Enable:
//     - Drop en at sel=1, cnt=4 -> next edge an_n=4'hF; cnt and sel frozen for 10 cycles; no slot_start.
//     - Raise en -> counting resumes at cnt=5, sel=1, with an_n=4'b1101.
//   6 Async reset mid-slot:
//     - reset_n falls between edges at sel=2, cnt=5 -> an_n=4'hF and sel=0 immediately, before the next edge.
//     - Release -> normal scan restarts from sel=0, cnt=0.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants and helpers for the display scan path.
// The digit select is decoded here so that the top and any future consumers decode it the same way.
package disp_pkg;

    localparam int         NUM_DIG     = 4;
    localparam int         SEL_W       = 2;
    localparam int         BRIGHT_W    = 4;
    localparam logic [3:0] BRIGHT_FULL = 4'hF;

    function automatic logic [NUM_DIG-1:0] dig_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_DIG-1:0] oh;
        oh = 4'b0000;
        case (sel)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_counter.sv
// Modulo-M up counter with hold enable; wrap flags the last count while enabled.
// Used for the slot counter and the digit counter of the scan controller.
module mod_counter #(
    parameter int M = 4,
    localparam int W = (M > 1) ? $clog2(M) : 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(M - 1);

    logic [W-1:0] cnt_r;
    logic         wrap_s;

    // Terminal-count detect, qualified by enable so a frozen counter never wraps.
    always_comb begin
        wrap_s = 1'b0;
        if (en && (cnt_r == LAST)) begin
            wrap_s = 1'b1;
        end else begin
            wrap_s = 1'b0;
        end
    end

    // Count register: advances only while enabled, returns to zero after M-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {W{1'b0}};
        end else if (en) begin
            if (cnt_r == LAST) begin
                cnt_r <= {W{1'b0}};
            end else begin
                cnt_r <= cnt_r + W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt  = cnt_r;
    assign wrap = wrap_s;

endmodule

// File: rtl/disp_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed display: digit select, blanked and PWM-dimmed anodes.
// Anodes are registered from next-state counter values so select and anode always change together.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int TICK_DIV  = 100_000,
    parameter int BLANK_CYC = 1_000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic [NUM_DIG-1:0]  digit_mask,
    input  logic [BRIGHT_W-1:0] bright,
    output logic [SEL_W-1:0]    sel,
    output logic [NUM_DIG-1:0]  an_n,
    output logic                slot_start
);

    localparam int            CW      = $clog2(TICK_DIV);
    localparam logic [CW-1:0] BLANK_V = CW'(BLANK_CYC);

    if (!((TICK_DIV > BLANK_CYC) && (BLANK_CYC >= 1))) begin : g_param_check
        $error("disp_scan_ctrl: require TICK_DIV > BLANK_CYC >= 1");
    end

    logic [CW-1:0]       cnt_s;
    logic                slot_wrap_s;
    logic [SEL_W-1:0]    sel_s;
    logic                dig_wrap_s;
    logic [CW-1:0]       cnt_nxt_s;
    logic [SEL_W-1:0]    sel_nxt_s;
    logic [BRIGHT_W-1:0] cnt_lo_s;
    logic                blank_done_s;
    logic                pwm_on_s;
    logic [NUM_DIG-1:0]  an_nxt_s;
    logic [NUM_DIG-1:0]  an_n_r;
    logic                slot_start_r;

    mod_counter #(.M(TICK_DIV)) u_slot_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .cnt     (cnt_s),
        .wrap    (slot_wrap_s)
    );

    mod_counter #(.M(NUM_DIG)) u_dig_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (slot_wrap_s),
        .cnt     (sel_s),
        .wrap    (dig_wrap_s)
    );

    // Next-state view of both counters, mirroring what they will hold after this edge.
    always_comb begin
        cnt_nxt_s = cnt_s;
        sel_nxt_s = sel_s;
        if (!en) begin
            cnt_nxt_s = cnt_s;
        end else if (slot_wrap_s) begin
            cnt_nxt_s = {CW{1'b0}};
        end else begin
            cnt_nxt_s = cnt_s + CW'(1);
        end
        if (!slot_wrap_s) begin
            sel_nxt_s = sel_s;
        end else if (dig_wrap_s) begin
            sel_nxt_s = 2'd0;
        end else begin
            sel_nxt_s = sel_s + 2'd1;
        end
    end

    // The PWM compares against the low nibble of the slot count; narrow counters are zero-extended.
    if (CW >= BRIGHT_W) begin : g_lo_slice
        assign cnt_lo_s = cnt_nxt_s[BRIGHT_W-1:0];
    end else begin : g_lo_ext
        assign cnt_lo_s = BRIGHT_W'(cnt_nxt_s);
    end

    // Lit decision: past the blanking gap, inside the duty window, and digit not masked.
    always_comb begin
        blank_done_s = 1'b0;
        pwm_on_s     = 1'b0;
        an_nxt_s     = 4'hF;
        if (cnt_nxt_s >= BLANK_V) begin
            blank_done_s = 1'b1;
        end else begin
            blank_done_s = 1'b0;
        end
        if ((bright == BRIGHT_FULL) || (cnt_lo_s < bright)) begin
            pwm_on_s = 1'b1;
        end else begin
            pwm_on_s = 1'b0;
        end
        if (en && blank_done_s && pwm_on_s) begin
            an_nxt_s = ~(dig_onehot(sel_nxt_s) & digit_mask);
        end else begin
            an_nxt_s = 4'hF;
        end
    end

    // Output registers for the anodes and the slot-boundary pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_n_r       <= 4'hF;
            slot_start_r <= 1'b0;
        end else begin
            an_n_r       <= an_nxt_s;
            slot_start_r <= slot_wrap_s;
        end
    end

    assign sel        = sel_s;
    assign an_n       = an_n_r;
    assign slot_start = slot_start_r;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Randomized and directed bench for disp_scan_ctrl against a slot-position reference model.
module tb_disp_scan_ctrl;

    localparam int TD = 8;
    localparam int BC = 2;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic [3:0] digit_mask;
    logic [3:0] bright;
    logic [1:0] sel;
    logic [3:0] an_n;
    logic       slot_start;

    int n_cmp;
    int n_bad;

    // Model: pos = enabled cycles since reset, modulo one full refresh (4 slots)
    int         pos;
    logic [1:0] e_sel;
    logic [3:0] e_an;
    logic       e_ss;

    disp_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYC(BC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .digit_mask (digit_mask),
        .bright     (bright),
        .sel        (sel),
        .an_n       (an_n),
        .slot_start (slot_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] exp_an(input int p);
        int c;
        int s;
        c = p % TD;
        s = p / TD;
        if (c >= BC && (bright == 4'hF || c < int'(bright)) && digit_mask[s])
            return ~(4'b0001 << s);
        return 4'hF;
    endfunction

    task automatic model_reset();
        pos   = 0;
        e_sel = 2'd0;
        e_an  = 4'hF;
        e_ss  = 1'b0;
    endtask

    // One clock edge: update the model with the inputs seen at the edge, then settle.
    task automatic tick();
        int c;
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else if (en) begin
            c     = pos % TD;
            pos   = (pos + 1) % (4 * TD);
            e_ss  = (c == TD - 1);
            e_sel = 2'(pos / TD);
            e_an  = exp_an(pos);
        end else begin
            e_ss = 1'b0;
            e_an = 4'hF;
        end
        #1;
    endtask

    task automatic test_reset();
        int first_ss;
        reset_n = 1'b0; en = 1'b1; digit_mask = 4'hF; bright = 4'hF;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({sel, an_n, slot_start} !== {2'd0, 4'hF, 1'b0}) begin
                n_bad++;
                $display("FAIL reset cyc%0d: got sel=%0d an_n=%b ss=%b, want 0 1111 0", i, sel, an_n, slot_start);
            end
        end
        reset_n = 1'b1;
        first_ss = -1;
        for (int i = 1; i <= TD; i++) begin
            tick();
            if (slot_start === 1'b1 && first_ss < 0) first_ss = i;
            n_cmp++;
            if ({sel, an_n, slot_start} !== {e_sel, e_an, e_ss}) begin
                n_bad++;
                $display("FAIL reset_release cyc%0d: got %0d %b %b, want %0d %b %b", i, sel, an_n, slot_start, e_sel, e_an, e_ss);
            end
        end
        n_cmp++;
        if (first_ss != TD) begin
            n_bad++;
            $display("FAIL first_slot_start: got cycle %0d, want %0d", first_ss, TD);
        end
    endtask

    task automatic test_full_scan();
        digit_mask = 4'hF; bright = 4'hF; en = 1'b1;
        for (int i = 0; i < 5 * TD; i++) begin
            tick();
            n_cmp++;
            if ({sel, an_n, slot_start} !== {e_sel, e_an, e_ss}) begin
                n_bad++;
                $display("FAIL full_scan cyc%0d: got %0d %b %b, want %0d %b %b", i, sel, an_n, slot_start, e_sel, e_an, e_ss);
            end
        end
    endtask

    task automatic test_mask();
        int n_ss;
        int bad_bits;
        digit_mask = 4'b0101; bright = 4'hF; en = 1'b1;
        tick();
        n_ss = 0; bad_bits = 0;
        for (int i = 0; i < 4 * TD; i++) begin
            tick();
            if (slot_start === 1'b1) n_ss++;
            if (an_n[1] !== 1'b1 || an_n[3] !== 1'b1) bad_bits++;
            n_cmp++;
            if ({sel, an_n, slot_start} !== {e_sel, e_an, e_ss}) begin
                n_bad++;
                $display("FAIL mask cyc%0d: got %0d %b %b, want %0d %b %b", i, sel, an_n, slot_start, e_sel, e_an, e_ss);
            end
        end
        n_cmp++;
        if (bad_bits != 0) begin
            n_bad++;
            $display("FAIL mask_dark_bits: got %0d cycles with bit1/3 low, want 0", bad_bits);
        end
        n_cmp++;
        if (n_ss != 4) begin
            n_bad++;
            $display("FAIL mask_slot_rate: got %0d slot_start in 32 cycles, want 4", n_ss);
        end
    endtask

    task automatic test_bright();
        logic [3:0] codes [3];
        int         want_per_slot [3];
        int         lit;
        codes[0] = 4'd4;  want_per_slot[0] = 2;
        codes[1] = 4'd0;  want_per_slot[1] = 0;
        codes[2] = 4'd15; want_per_slot[2] = 6;
        digit_mask = 4'hF; en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bright = codes[k];
            tick();
            lit = 0;
            for (int i = 0; i < 4 * TD; i++) begin
                tick();
                if (an_n !== 4'hF) lit++;
                n_cmp++;
                if ({sel, an_n, slot_start} !== {e_sel, e_an, e_ss}) begin
                    n_bad++;
                    $display("FAIL bright%0d cyc%0d: got %0d %b %b, want %0d %b %b", codes[k], i, sel, an_n, slot_start, e_sel, e_an, e_ss);
                end
            end
            n_cmp++;
            if (lit != 4 * want_per_slot[k]) begin
                n_bad++;
                $display("FAIL bright%0d_lit: got %0d lit cycles per refresh, want %0d", codes[k], lit, 4 * want_per_slot[k]);
            end
        end
    endtask

    task automatic test_enable();
        bit found;
        digit_mask = 4'hF; bright = 4'hF; en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 8 * TD && !found; i++) begin
            tick();
            if (pos == TD + 4) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL enable_wait: got timeout, want sel=1 cnt=4");
        end
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if ({sel, an_n, slot_start} !== {2'd1, 4'hF, 1'b0} || {sel, an_n, slot_start} !== {e_sel, e_an, e_ss}) begin
                n_bad++;
                $display("FAIL enable_frozen cyc%0d: got %0d %b %b, want 1 1111 0", i, sel, an_n, slot_start);
            end
        end
        en = 1'b1;
        tick();
        n_cmp++;
        if ({sel, an_n, slot_start} !== {2'd1, 4'b1101, 1'b0} || pos != TD + 5) begin
            n_bad++;
            $display("FAIL enable_resume: got %0d %b %b, want 1 1101 0", sel, an_n, slot_start);
        end
    endtask

    task automatic test_async_reset();
        bit found;
        digit_mask = 4'hF; bright = 4'hF; en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 8 * TD && !found; i++) begin
            tick();
            if (pos == 2 * TD + 5) found = 1'b1;
        end
        n_cmp++;
        if (!found || an_n !== 4'b1011) begin
            n_bad++;
            $display("FAIL async_wait: got an_n=%b found=%0d, want 1011 at sel=2 cnt=5", an_n, found);
        end
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if ({sel, an_n, slot_start} !== {2'd0, 4'hF, 1'b0}) begin
            n_bad++;
            $display("FAIL async_immediate: got %0d %b %b, want 0 1111 0", sel, an_n, slot_start);
        end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 2 * TD; i++) begin
            tick();
            n_cmp++;
            if ({sel, an_n, slot_start} !== {e_sel, e_an, e_ss}) begin
                n_bad++;
                $display("FAIL async_restart cyc%0d: got %0d %b %b, want %0d %b %b", i, sel, an_n, slot_start, e_sel, e_an, e_ss);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en         = ($urandom_range(0, 3) != 0);
            digit_mask = 4'($urandom);
            bright     = 4'($urandom);
            tick();
            n_cmp++;
            if ({sel, an_n, slot_start} !== {e_sel, e_an, e_ss}) begin
                n_bad++;
                $display("FAIL random cyc%0d: got %0d %b %b, want %0d %b %b", i, sel, an_n, slot_start, e_sel, e_an, e_ss);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_full_scan();
        test_mask();
        test_bright();
        test_enable();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
